// File: rtl/pipe_hazard_unit_if.sv
// Execute-stage hazard interface: ex_* instruction fields toward the hazard
// unit, forwarding selects / stall / flush back to the datapath.
interface pipe_hazard_unit_if #(
  parameter int NREG  = 32,
  parameter int DEPTH = 2
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH + 1);

  logic          ex_valid;
  logic [AW-1:0] ex_rs1;
  logic [AW-1:0] ex_rs2;
  logic          ex_use_rs1;
  logic          ex_use_rs2;
  logic [AW-1:0] ex_rd;
  logic          ex_reg_wr;
  logic          ex_is_load;
  logic          br_taken;
  logic [SW-1:0] fwd_sel_a;
  logic [SW-1:0] fwd_sel_b;
  logic          stall;
  logic          flush;

  modport master (
    output ex_valid, ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2,
           ex_rd, ex_reg_wr, ex_is_load, br_taken,
    input  fwd_sel_a, fwd_sel_b, stall, flush
  );

  modport slave (
    input  ex_valid, ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2,
           ex_rd, ex_reg_wr, ex_is_load, br_taken,
    output fwd_sel_a, fwd_sel_b, stall, flush
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based forwarding / load-use stall / branch flush controller.
// Optional event counters are built when HAZARD_STATS_EN is defined.
module pipe_hazard_unit #(
  parameter int NREG     = 32,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_unit_if.slave  hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH + 1);

  logic [DEPTH:1] v_q, v_d;
  logic [DEPTH:1] wr_q, wr_d;
  logic [DEPTH:1] ld_q, ld_d;
  logic [AW-1:0]  rd_q [1:DEPTH];
  logic [AW-1:0]  rd_d [1:DEPTH];

  logic          hit_a, hit_b, ldw_a, ldw_b;
  logic [SW-1:0] sel_a, sel_b;
  logic          lu_a, lu_b, stall_o, flush_o;

  // Youngest producer wins: scan from stage 1 and keep only the first hit.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    ldw_a = 1'b0;
    ldw_b = 1'b0;
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!hit_a && hz.ex_use_rs1 && (hz.ex_rs1 != '0) && v_q[k] && wr_q[k] &&
          (rd_q[k] == hz.ex_rs1)) begin
        hit_a = 1'b1;
        sel_a = SW'(k);
        ldw_a = ld_q[k];
      end
      if (!hit_b && hz.ex_use_rs2 && (hz.ex_rs2 != '0) && v_q[k] && wr_q[k] &&
          (rd_q[k] == hz.ex_rs2)) begin
        hit_b = 1'b1;
        sel_b = SW'(k);
        ldw_b = ld_q[k];
      end
    end
    lu_a    = hit_a && ldw_a && (int'(sel_a) <= LOAD_LAT);
    lu_b    = hit_b && ldw_b && (int'(sel_b) <= LOAD_LAT);
    stall_o = !reset && hz.ex_valid && (lu_a || lu_b);
    flush_o = !reset && hz.ex_valid && hz.br_taken && !stall_o;
  end

  assign hz.fwd_sel_a = sel_a;
  assign hz.fwd_sel_b = sel_b;
  assign hz.stall     = stall_o;
  assign hz.flush     = flush_o;

  // Older entries always shift; a stall only replaces the new entry with a bubble.
  always_comb begin
    v_d  = v_q;
    wr_d = wr_q;
    ld_d = ld_q;
    rd_d = rd_q;
    for (int unsigned k = DEPTH; k >= 2; k--) begin
      v_d[k]  = v_q[k-1];
      wr_d[k] = wr_q[k-1];
      ld_d[k] = ld_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
    if (stall_o) begin
      v_d[1]  = 1'b0;
      wr_d[1] = 1'b0;
      ld_d[1] = 1'b0;
      rd_d[1] = hz.ex_rd;
    end else begin
      v_d[1]  = hz.ex_valid;
      wr_d[1] = hz.ex_valid && hz.ex_reg_wr && (hz.ex_rd != '0);
      ld_d[1] = hz.ex_is_load;
      rd_d[1] = hz.ex_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      wr_q <= '0;
      ld_q <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) rd_q[k] <= '0;
    end else begin
      v_q  <= v_d;
      wr_q <= wr_d;
      ld_q <= ld_d;
      for (int unsigned k = 1; k <= DEPTH; k++) rd_q[k] <= rd_d[k];
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(stall_o);
    flush_cnt_d = flush_cnt_q + 32'(flush_o);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomized + directed bench for pipe_hazard_unit across three configurations,
// checked against a history-queue reference model.
module tb_pipe_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.NREG(32), .DEPTH(2)) if0 ();
  pipe_hazard_unit_if #(.NREG(32), .DEPTH(2)) if1 ();
  pipe_hazard_unit_if #(.NREG(32), .DEPTH(4)) if2 ();

`ifdef HAZARD_STATS_EN
  logic [31:0] scnt0, scnt1, scnt2, fcnt0, fcnt1, fcnt2;
  pipe_hazard_unit #(.NREG(32), .DEPTH(2), .LOAD_LAT(1)) dut0 (
    .clk(clk), .reset(rst), .hz(if0), .stall_cnt(scnt0), .flush_cnt(fcnt0));
  pipe_hazard_unit #(.NREG(32), .DEPTH(2), .LOAD_LAT(0)) dut1 (
    .clk(clk), .reset(rst), .hz(if1), .stall_cnt(scnt1), .flush_cnt(fcnt1));
  pipe_hazard_unit #(.NREG(32), .DEPTH(4), .LOAD_LAT(2)) dut2 (
    .clk(clk), .reset(rst), .hz(if2), .stall_cnt(scnt2), .flush_cnt(fcnt2));
`else
  pipe_hazard_unit #(.NREG(32), .DEPTH(2), .LOAD_LAT(1)) dut0 (
    .clk(clk), .reset(rst), .hz(if0));
  pipe_hazard_unit #(.NREG(32), .DEPTH(2), .LOAD_LAT(0)) dut1 (
    .clk(clk), .reset(rst), .hz(if1));
  pipe_hazard_unit #(.NREG(32), .DEPTH(4), .LOAD_LAT(2)) dut2 (
    .clk(clk), .reset(rst), .hz(if2));
`endif

  typedef struct packed {
    logic       v;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } ent_t;

  // Reference: per-configuration history of instructions that left execute (youngest first).
  ent_t        hist [3][$];
  int          depth_c [3] = '{2, 2, 4};
  int          lat_c   [3] = '{1, 0, 2};
  int          m_sel_a [3];
  int          m_sel_b [3];
  bit          m_stall [3];
  bit          m_flush [3];
  int unsigned m_scnt  [3];
  int unsigned m_fcnt  [3];

  logic       s_valid, s_u1, s_u2, s_wr, s_ld, s_br;
  logic [4:0] s_rs1, s_rs2, s_rd;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic br);
    s_valid = v; s_rs1 = rs1; s_u1 = u1; s_rs2 = rs2; s_u2 = u2;
    s_rd = rd; s_wr = wr; s_ld = ld; s_br = br;
    if0.ex_valid = v; if0.ex_rs1 = rs1; if0.ex_use_rs1 = u1; if0.ex_rs2 = rs2;
    if0.ex_use_rs2 = u2; if0.ex_rd = rd; if0.ex_reg_wr = wr; if0.ex_is_load = ld;
    if0.br_taken = br;
    if1.ex_valid = v; if1.ex_rs1 = rs1; if1.ex_use_rs1 = u1; if1.ex_rs2 = rs2;
    if1.ex_use_rs2 = u2; if1.ex_rd = rd; if1.ex_reg_wr = wr; if1.ex_is_load = ld;
    if1.br_taken = br;
    if2.ex_valid = v; if2.ex_rs1 = rs1; if2.ex_use_rs1 = u1; if2.ex_rs2 = rs2;
    if2.ex_use_rs2 = u2; if2.ex_rd = rd; if2.ex_reg_wr = wr; if2.ex_is_load = ld;
    if2.br_taken = br;
  endtask

  task automatic model_sel(input int i, input logic u, input logic [4:0] rs,
                           output int sel, output bit ld);
    sel = 0;
    ld  = 1'b0;
    if (u && rs != 5'd0) begin
      for (int k = 0; k < hist[i].size(); k++) begin
        if (sel == 0 && hist[i][k].v && hist[i][k].wr && hist[i][k].rd == rs) begin
          sel = k + 1;
          ld  = hist[i][k].ld;
        end
      end
    end
  endtask

  task automatic model_eval();
    for (int i = 0; i < 3; i++) begin
      int sa, sb;
      bit la, lb;
      model_sel(i, s_u1, s_rs1, sa, la);
      model_sel(i, s_u2, s_rs2, sb, lb);
      m_sel_a[i] = sa;
      m_sel_b[i] = sb;
      m_stall[i] = !rst && s_valid &&
                   ((sa != 0 && la && sa <= lat_c[i]) || (sb != 0 && lb && sb <= lat_c[i]));
      m_flush[i] = !rst && s_valid && s_br && !m_stall[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i].delete();
      m_scnt[i] = 0;
      m_fcnt[i] = 0;
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        ent_t e;
        e = '0;
        if (!m_stall[i]) begin
          e.v  = s_valid;
          e.wr = s_valid && s_wr && (s_rd != 5'd0);
          e.ld = s_ld;
          e.rd = s_rd;
        end
        m_scnt[i] += 32'(m_stall[i]);
        m_fcnt[i] += 32'(m_flush[i]);
        hist[i].push_front(e);
        if (hist[i].size() > depth_c[i]) void'(hist[i].pop_back());
      end
    end
  endtask

  task automatic cmp();
    logic [31:0] ga, gb, gs, gf;
    model_eval();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin ga = 32'(if0.fwd_sel_a); gb = 32'(if0.fwd_sel_b); gs = 32'(if0.stall); gf = 32'(if0.flush); end
        1: begin ga = 32'(if1.fwd_sel_a); gb = 32'(if1.fwd_sel_b); gs = 32'(if1.stall); gf = 32'(if1.flush); end
        default: begin ga = 32'(if2.fwd_sel_a); gb = 32'(if2.fwd_sel_b); gs = 32'(if2.stall); gf = 32'(if2.flush); end
      endcase
      chk($sformatf("cfg%0d fwd_sel_a", i), ga, 32'(m_sel_a[i]));
      chk($sformatf("cfg%0d fwd_sel_b", i), gb, 32'(m_sel_b[i]));
      chk($sformatf("cfg%0d stall", i), gs, 32'(m_stall[i]));
      chk($sformatf("cfg%0d flush", i), gf, 32'(m_flush[i]));
    end
`ifdef HAZARD_STATS_EN
    chk("cfg0 stall_cnt", scnt0, m_scnt[0]);
    chk("cfg1 stall_cnt", scnt1, m_scnt[1]);
    chk("cfg2 stall_cnt", scnt2, m_scnt[2]);
    chk("cfg0 flush_cnt", fcnt0, m_fcnt[0]);
    chk("cfg1 flush_cnt", fcnt1, m_fcnt[1]);
    chk("cfg2 flush_cnt", fcnt2, m_fcnt[2]);
`endif
  endtask

  task automatic settle();
    #3;
    cmp();
  endtask

  task automatic adv();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    model_reset();
    // Reset held with a taken branch present: everything must read zero.
    drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    settle();
    chk("rst flush", 32'(if0.flush), 0);
    chk("rst stall", 32'(if0.stall), 0);
    adv();
    rst = 1'b0;

    // addi x5,x0,7 ; add x6,x5,x5
    drive(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0); settle(); adv();
    drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0); settle();
    chk("alu dep sel_a", 32'(if0.fwd_sel_a), 1);
    chk("alu dep sel_b", 32'(if0.fwd_sel_b), 1);
    chk("alu dep stall", 32'(if0.stall), 0);
    adv();

    // lw x7,0(x1) ; add x8,x7,x2 (held while stalled)
    drive(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0); settle(); adv();
    drive(1, 5'd7, 1, 5'd2, 1, 5'd8, 1, 0, 0); settle();
    chk("load use stall", 32'(if0.stall), 1);
    chk("load use lat0 stall", 32'(if1.stall), 0);
    chk("load use lat0 sel_a", 32'(if1.fwd_sel_a), 1);
    adv();
    settle();
    chk("load use after stall", 32'(if0.stall), 0);
    chk("load use sel_a", 32'(if0.fwd_sel_a), 2);
    chk("load use sel_b", 32'(if0.fwd_sel_b), 0);
    adv();

    // Youngest producer wins, then x0 never forwarded
    drive(1, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0, 0); settle(); adv();
    drive(1, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0, 0); settle(); adv();
    drive(1, 5'd3, 1, 5'd0, 1, 5'd4, 1, 0, 0); settle();
    chk("youngest sel_a", 32'(if0.fwd_sel_a), 1);
    chk("youngest sel_b", 32'(if0.fwd_sel_b), 0);
    adv();
    drive(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 1, 0); settle(); adv();
    drive(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0); settle();
    chk("x0 sel_a", 32'(if0.fwd_sel_a), 0);
    chk("x0 stall", 32'(if0.stall), 0);
    adv();

    // Taken branch without hazard, then branch on a fresh load
    drive(1, 5'd9, 1, 5'd0, 1, 5'd0, 0, 0, 1); settle();
    chk("branch flush", 32'(if0.flush), 1);
    adv();
    drive(1, 5'd1, 1, 5'd0, 0, 5'd10, 1, 1, 0); settle(); adv();
    drive(1, 5'd10, 1, 5'd0, 1, 5'd0, 0, 0, 1); settle();
    chk("br on load stall", 32'(if0.stall), 1);
    chk("br on load flush", 32'(if0.flush), 0);
    adv();
    settle();
    chk("br after stall flush", 32'(if0.flush), 1);
    adv();

    // Reset asserted mid-stall drops stall without a clock edge
    drive(1, 5'd1, 1, 5'd0, 0, 5'd11, 1, 1, 0); settle(); adv();
    drive(1, 5'd11, 1, 5'd11, 1, 5'd12, 1, 0, 0); settle();
    chk("pre reset stall", 32'(if0.stall), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    cmp();
    chk("async reset stall", 32'(if0.stall), 0);
    adv();
    rst = 1'b0;
    settle();
    chk("post reset sel_a", 32'(if0.fwd_sel_a), 0);
    chk("post reset sel_b", 32'(if2.fwd_sel_b), 0);
`ifdef HAZARD_STATS_EN
    chk("post reset stall_cnt", scnt0, 0);
`endif
    adv();

    // Randomized traffic with a small register window for frequent hazards
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) != 0,
            5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0);
      settle();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard controller for the in-order RISC-V pipeline, replacing the fixed single-stage forwarding check. It keeps a shift-register scoreboard of destination registers for up to DEPTH stages after execute. From that scoreboard it selects the forwarding source for each execute operand, stalls on load-use hazards that forwarding cannot cover, and produces the branch flush. It sits beside the execute stage; the datapath muxes operands from `fwd_sel_a`/`fwd_sel_b` and holds fetch/execute on `stall`.

## Interface
- `NREG`, default 32: architectural register count; AW = $clog2(NREG).
- `DEPTH`, default 2: tracked post-execute stages, 1..4; SW = $clog2(DEPTH+1).
- `LOAD_LAT`, default 1: stages a load needs after execute before its data can be forwarded, 0..DEPTH-1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears the scoreboard and, under `HAZARD_STATS_EN`, the counters.
- `ex_valid` in 1: execute stage holds a real instruction.
- `ex_rs1`, `ex_rs2` in AW: execute source registers.
- `ex_use_rs1`, `ex_use_rs2` in 1: the instruction actually reads that source.
- `ex_rd` in AW: execute destination.
- `ex_reg_wr` in 1: execute instruction writes `ex_rd`.
- `ex_is_load` in 1: execute instruction is a load.
- `br_taken` in 1: branch/jump resolved taken in execute.
- `fwd_sel_a`, `fwd_sel_b` out SW: 0 = register file; k = result of stage k (1 = youngest).
- `stall` out 1: hold PC and execute register; bubble enters stage 1.
- `flush` out 1: replace the fetched instruction with a NOP (0x00000013).
- `stall_cnt`, `flush_cnt` out 32: event counters; present only with `HAZARD_STATS_EN`.

## Operation
- The scoreboard holds DEPTH entries, each {v, wr, ld, rd}. Entry 1 is the instruction one cycle past execute.
- Every clock edge the scoreboard shifts: entry k moves to k+1, and entry DEPTH is discarded.
- Entry 1 load, no stall: v = ex_valid, wr = ex_valid & ex_reg_wr & (ex_rd != 0), ld = ex_is_load, rd = ex_rd.
- Entry 1 load, stall: a bubble is inserted (v = wr = ld = 0). Older entries still shift.
- Operand match for source s, stage k: use_s & (rs_s != 0) & v_k & wr_k & (rd_k == rs_s).
- Forwarding: the smallest matching k wins (youngest producer). No match gives 0. x0 is never forwarded.
- Load-use: if the winning match for either operand is a load with k <= LOAD_LAT, then stall = ex_valid = 1.
  - An older non-load match never masks a younger load match.
- While stalled, `fwd_sel_a`/`fwd_sel_b` still show the winning match. The datapath ignores them.
- Stall self-clears once the load shifts past LOAD_LAT. Maximum consecutive stall cycles = LOAD_LAT.
- flush = ex_valid & br_taken & ~stall. A stall takes priority over the branch, because the branch operands are not yet valid.
- With LOAD_LAT = 0, stall is constantly 0.

## Timing
- `fwd_sel_*`, `stall` and `flush` are combinational from the ex_* inputs and the scoreboard. Zero-cycle latency within the execute cycle.
- Scoreboard update: one cycle. A producer in execute at cycle t matches as stage 1 at t+1 and as stage k at t+k.
- A producer older than DEPTH stages is not forwarded. The register file must already hold its value (write-before-read).
- Reset values: all entries v = 0. fwd_sel_a = fwd_sel_b = 0, stall = 0, flush = 0, counters 0.
  - flush and stall are forced to 0 while `reset` is high, regardless of inputs.
- Reset asserted mid-stall clears the scoreboard immediately. Stall drops asynchronously.
- Reset deassertion is synchronised by the integrating top. The block makes no assumption about deassertion timing.
- Simultaneous matches:
  - rs1 == rs2: both selects are equal.
  - Multiple stages match: the youngest wins.
  - Producer and consumer are the same instruction (rs == rd in execute): this is not a hazard. Only scoreboard entries are compared.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_cnt` increments on every cycle with stall = 1.
  - `flush_cnt` increments on every cycle with flush = 1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- `HAZARD_STATS_EN` undefined: the counter ports and logic are absent. The rest of the behaviour is identical.

## Test plan
- Back-to-back ALU dependency, DEPTH = 2, LOAD_LAT = 1: `addi x5,x0,7` then `add x6,x5,x5` -> second instruction gets fwd_sel_a = fwd_sel_b = 1, stall = 0.
- Load-use: `lw x7,0(x1)` then `add x8,x7,x2` -> exactly 1 stall cycle, then fwd_sel_a = 2, fwd_sel_b = 0.
  - With LOAD_LAT = 0, the same pair gives no stall and fwd_sel_a = 1.
- Youngest wins: `addi x3,x0,1`, `addi x3,x0,2`, `add x4,x3,x0` -> fwd_sel_a = 1, forwarding value 2.
  - With rs1 = x0 and rd = x0 everywhere, all selects are 0.
- Branch/stall priority: a taken `beq` in execute with no hazard -> flush = 1 for one cycle.
  - A taken branch that depends on a load in stage 1 -> stall = 1 and flush = 0 first; flush = 1 on the following cycle.
- Reset mid-stall: assert reset during a load-use stall -> stall falls without waiting for a clock. After release, every select is 0 until new producers enter.
  - With `HAZARD_STATS_EN`, stall_cnt returns to 0.
